// File: rtl/branch_rs.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | branch_rs : collapsing-queue reservation station for branch resolution
// | Revision  : 1.0
// +----------------------------------------------------------------------------
module branch_rs #(
   parameter int ROB_IX   = 2,
   parameter int RS_DEPTH = 4
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              dispatch_valid_in,
   output logic              dispatch_ready_out,
   input  logic [2:0]        dispatch_brfunc_in,
   input  logic [31:0]       dispatch_pc_in,
   input  logic [31:0]       dispatch_imm_in,
   input  logic              dispatch_pred_taken_in,
   input  logic [ROB_IX-1:0] dispatch_robix_in,
   input  logic              src1_rdy_in,
   input  logic [31:0]       src1_val_in,
   input  logic [ROB_IX-1:0] src1_tag_in,
   input  logic              src2_rdy_in,
   input  logic [31:0]       src2_val_in,
   input  logic [ROB_IX-1:0] src2_tag_in,
   input  logic              cdb_valid_in,
   input  logic [ROB_IX-1:0] cdb_tag_in,
   input  logic [31:0]       cdb_val_in,
   input  logic              flush_in,
   output logic [31:0]       alu_rval1_out,
   output logic [31:0]       alu_rval2_out,
   output logic [2:0]        alu_brfunc_out,
   input  logic              alu_bool_in,
   output logic              res_valid_out,
   output logic [ROB_IX-1:0] res_robix_out,
   output logic              res_taken_out,
   output logic [31:0]       res_target_out,
   output logic              res_mispredict_out
);

   localparam int IW = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;
   localparam int CW = $clog2(RS_DEPTH + 1);
   localparam logic [CW-1:0] DEPTH_C = CW'(RS_DEPTH);

   typedef struct packed {
      logic              valid;
      logic [2:0]        brfunc;
      logic [31:0]       pc;
      logic [31:0]       imm;
      logic              pred;
      logic [ROB_IX-1:0] robix;
      logic              rdy1;
      logic [31:0]       val1;
      logic [ROB_IX-1:0] tag1;
      logic              rdy2;
      logic [31:0]       val2;
      logic [ROB_IX-1:0] tag2;
   } entry_t;

   entry_t          ent     [RS_DEPTH];
   entry_t          ent_nxt [RS_DEPTH];
   entry_t          new_ent;
   logic [CW-1:0]   count;
   logic [CW-1:0]   count_nxt;
   logic [CW-1:0]   base;
   logic            sel_valid;
   logic [IW-1:0]   sel;
   logic            accept;
   logic            taken;

   // Scan from the top so the lowest ready index wins.
   always_comb begin
      sel_valid = 1'b0;
      sel       = '0;
      for (int i = RS_DEPTH - 1; i >= 0; i--) begin
         if (ent[i].valid && ent[i].rdy1 && ent[i].rdy2) begin
            sel_valid = 1'b1;
            sel       = IW'(i);
         end
      end
   end

   assign dispatch_ready_out = (count < DEPTH_C);
   assign accept             = dispatch_valid_in && dispatch_ready_out && !flush_in;

   assign alu_rval1_out  = sel_valid ? ent[sel].val1   : 32'd0;
   assign alu_rval2_out  = sel_valid ? ent[sel].val2   : 32'd0;
   assign alu_brfunc_out = sel_valid ? ent[sel].brfunc : 3'd0;
   assign taken          = sel_valid && (ent[sel].brfunc <= 3'd5) && alu_bool_in;

   always_comb begin
      new_ent        = '0;
      new_ent.valid  = 1'b1;
      new_ent.brfunc = dispatch_brfunc_in;
      new_ent.pc     = dispatch_pc_in;
      new_ent.imm    = dispatch_imm_in;
      new_ent.pred   = dispatch_pred_taken_in;
      new_ent.robix  = dispatch_robix_in;
      new_ent.tag1   = src1_tag_in;
      new_ent.tag2   = src2_tag_in;
      new_ent.rdy1   = src1_rdy_in || (cdb_valid_in && cdb_tag_in == src1_tag_in);
      new_ent.val1   = src1_rdy_in ? src1_val_in : cdb_val_in;
      new_ent.rdy2   = src2_rdy_in || (cdb_valid_in && cdb_tag_in == src2_tag_in);
      new_ent.val2   = src2_rdy_in ? src2_val_in : cdb_val_in;
   end

   always_comb begin
      for (int i = 0; i < RS_DEPTH - 1; i++) begin
         ent_nxt[i] = (sel_valid && IW'(i) >= sel) ? ent[i+1] : ent[i];
      end
      ent_nxt[RS_DEPTH-1] = sel_valid ? '0 : ent[RS_DEPTH-1];

      for (int i = 0; i < RS_DEPTH; i++) begin
         if (ent_nxt[i].valid && !ent_nxt[i].rdy1 && cdb_valid_in &&
             ent_nxt[i].tag1 == cdb_tag_in) begin
            ent_nxt[i].rdy1 = 1'b1;
            ent_nxt[i].val1 = cdb_val_in;
         end
         if (ent_nxt[i].valid && !ent_nxt[i].rdy2 && cdb_valid_in &&
             ent_nxt[i].tag2 == cdb_tag_in) begin
            ent_nxt[i].rdy2 = 1'b1;
            ent_nxt[i].val2 = cdb_val_in;
         end
      end

      // New entry lands just above the post-collapse occupancy.
      base = count - CW'(sel_valid);
      for (int i = 0; i < RS_DEPTH; i++) begin
         if (accept && CW'(i) == base) begin
            ent_nxt[i] = new_ent;
         end
      end
      count_nxt = count - CW'(sel_valid) + CW'(accept);
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         for (int i = 0; i < RS_DEPTH; i++) begin
            ent[i] <= '0;
         end
         count              <= '0;
         res_valid_out      <= 1'b0;
         res_robix_out      <= '0;
         res_taken_out      <= 1'b0;
         res_target_out     <= 32'd0;
         res_mispredict_out <= 1'b0;
      end else if (flush_in) begin
         for (int i = 0; i < RS_DEPTH; i++) begin
            ent[i] <= '0;
         end
         count         <= '0;
         res_valid_out <= 1'b0;
      end else begin
         for (int i = 0; i < RS_DEPTH; i++) begin
            ent[i] <= ent_nxt[i];
         end
         count         <= count_nxt;
         res_valid_out <= sel_valid;
         if (sel_valid) begin
            res_robix_out      <= ent[sel].robix;
            res_taken_out      <= taken;
            res_target_out     <= taken ? ent[sel].pc + ent[sel].imm : ent[sel].pc + 32'd4;
            res_mispredict_out <= taken ^ ent[sel].pred;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_branch_rs.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | tb_branch_rs : scoreboard bench for branch_rs
// | Revision     : 1.0
// +----------------------------------------------------------------------------
module tb_branch_rs;

   localparam int ROB_IX   = 2;
   localparam int RS_DEPTH = 4;

   logic              clk;
   logic              rst;
   logic              dispatch_valid, dispatch_ready;
   logic [2:0]        dispatch_brfunc;
   logic [31:0]       dispatch_pc, dispatch_imm;
   logic              dispatch_pred;
   logic [ROB_IX-1:0] dispatch_robix;
   logic              src1_rdy, src2_rdy;
   logic [31:0]       src1_val, src2_val;
   logic [ROB_IX-1:0] src1_tag, src2_tag;
   logic              cdb_valid;
   logic [ROB_IX-1:0] cdb_tag;
   logic [31:0]       cdb_val;
   logic              flush;
   logic [31:0]       alu_rval1, alu_rval2;
   logic [2:0]        alu_brfunc;
   logic              alu_bool;
   logic              res_valid, res_taken, res_mispredict;
   logic [ROB_IX-1:0] res_robix;
   logic [31:0]       res_target;

   typedef struct packed {
      logic [ROB_IX-1:0] robix;
      logic              taken;
      logic [31:0]       target;
      logic              mis;
   } exp_t;

   exp_t sb [$];
   exp_t mon_e;
   int   tests = 0;
   int   fails = 0;

   branch_rs #(.ROB_IX(ROB_IX), .RS_DEPTH(RS_DEPTH)) dut (
      .clk_in(clk), .rst_in(rst),
      .dispatch_valid_in(dispatch_valid), .dispatch_ready_out(dispatch_ready),
      .dispatch_brfunc_in(dispatch_brfunc), .dispatch_pc_in(dispatch_pc),
      .dispatch_imm_in(dispatch_imm), .dispatch_pred_taken_in(dispatch_pred),
      .dispatch_robix_in(dispatch_robix),
      .src1_rdy_in(src1_rdy), .src1_val_in(src1_val), .src1_tag_in(src1_tag),
      .src2_rdy_in(src2_rdy), .src2_val_in(src2_val), .src2_tag_in(src2_tag),
      .cdb_valid_in(cdb_valid), .cdb_tag_in(cdb_tag), .cdb_val_in(cdb_val),
      .flush_in(flush),
      .alu_rval1_out(alu_rval1), .alu_rval2_out(alu_rval2),
      .alu_brfunc_out(alu_brfunc), .alu_bool_in(alu_bool),
      .res_valid_out(res_valid), .res_robix_out(res_robix),
      .res_taken_out(res_taken), .res_target_out(res_target),
      .res_mispredict_out(res_mispredict)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Codes above 5 report true so the station's own masking is exercised.
   function automatic logic cmp(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      case (f)
         3'd0:    return a == b;
         3'd1:    return a != b;
         3'd2:    return $signed(a) <  $signed(b);
         3'd3:    return $signed(a) >= $signed(b);
         3'd4:    return a <  b;
         3'd5:    return a >= b;
         default: return 1'b1;
      endcase
   endfunction

   assign alu_bool = cmp(alu_brfunc, alu_rval1, alu_rval2);

   function automatic exp_t model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] pc, input logic [31:0] imm,
                                  input logic pred, input logic [ROB_IX-1:0] rob);
      exp_t e;
      e.robix  = rob;
      e.taken  = (f <= 3'd5) ? cmp(f, a, b) : 1'b0;
      e.target = e.taken ? pc + imm : pc + 32'd4;
      e.mis    = e.taken ^ pred;
      return e;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      if (obs !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (res_valid === 1'b1) begin
         if (sb.size() == 0) begin
            check("res_unexpected", 32'(res_valid), 32'd0);
         end else begin
            mon_e = sb.pop_front();
            check("res_robix",  32'(res_robix),      32'(mon_e.robix));
            check("res_taken",  32'(res_taken),      32'(mon_e.taken));
            check("res_target", res_target,          mon_e.target);
            check("res_mis",    32'(res_mispredict), 32'(mon_e.mis));
         end
      end
   end

   task automatic disp(input logic [2:0] f, input logic [31:0] pc, input logic [31:0] imm,
                       input logic pred, input logic [ROB_IX-1:0] rob,
                       input logic r1, input logic [31:0] v1, input logic [ROB_IX-1:0] t1,
                       input logic r2, input logic [31:0] v2, input logic [ROB_IX-1:0] t2);
      dispatch_brfunc = f;  dispatch_pc = pc;  dispatch_imm = imm;
      dispatch_pred   = pred; dispatch_robix = rob;
      src1_rdy = r1; src1_val = v1; src1_tag = t1;
      src2_rdy = r2; src2_val = v2; src2_tag = t2;
      dispatch_valid = 1'b1;
      @(negedge clk);
      dispatch_valid = 1'b0;
   endtask

   task automatic cdb(input logic [ROB_IX-1:0] tag, input logic [31:0] val);
      cdb_valid = 1'b1; cdb_tag = tag; cdb_val = val;
      @(negedge clk);
      cdb_valid = 1'b0;
   endtask

   task automatic drain(input string tag);
      int n = 0;
      while (sb.size() != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      #1;
      check(tag, 32'(sb.size()), 32'd0);
   endtask

   initial begin
      logic [2:0]  f;
      logic [31:0] a, b, pc, imm;
      logic        pred;

      rst = 1'b1; flush = 1'b0; dispatch_valid = 1'b0; cdb_valid = 1'b0;
      cdb_tag = '0; cdb_val = '0;
      dispatch_brfunc = '0; dispatch_pc = '0; dispatch_imm = '0; dispatch_pred = 1'b0;
      dispatch_robix = '0; src1_rdy = 1'b0; src1_val = '0; src1_tag = '0;
      src2_rdy = 1'b0; src2_val = '0; src2_tag = '0;

      @(negedge clk);
      check("rst_ready",     32'(dispatch_ready), 32'd1);
      check("rst_res_valid", 32'(res_valid),      32'd0);
      check("rst_alu_func",  32'(alu_brfunc),     32'd0);
      check("rst_res_tgt",   res_target,          32'd0);
      check("rst_res_robix", 32'(res_robix),      32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Signed less-than, already-ready operands
      sb.push_back(model(3'd2, 32'hFFFFFFFF, 32'd1, 32'h100, 32'h20, 1'b0, 2'd0));
      disp(3'd2, 32'h100, 32'h20, 1'b0, 2'd0, 1'b1, 32'hFFFFFFFF, 2'd0, 1'b1, 32'd1, 2'd0);
      check("lt_lat1",     32'(res_valid),  32'd0);
      check("lt_alu_func", 32'(alu_brfunc), 32'd2);
      @(negedge clk);
      check("lt_lat2",     32'(res_valid),  32'd1);

      // Bne waiting on tag 1
      disp(3'd1, 32'h200, 32'h40, 1'b0, 2'd1, 1'b1, 32'd5, 2'd0, 1'b0, 32'd0, 2'd1);
      check("bne_wait_alu", 32'(alu_brfunc), 32'd0);
      check("bne_wait_val", alu_rval1,       32'd0);
      sb.push_back(model(3'd1, 32'd5, 32'd5, 32'h200, 32'h40, 1'b0, 2'd1));
      cdb(2'd1, 32'd5);
      check("bne_wake_val2", alu_rval2,       32'd5);
      check("bne_res_pre",   32'(res_valid),  32'd0);
      @(negedge clk);
      check("bne_res",       32'(res_valid),  32'd1);

      // CDB broadcast in the dispatch cycle must be captured
      sb.push_back(model(3'd0, 32'd7, 32'd7, 32'h300, 32'h10, 1'b1, 2'd2));
      cdb_valid = 1'b1; cdb_tag = 2'd2; cdb_val = 32'd7;
      disp(3'd0, 32'h300, 32'h10, 1'b1, 2'd2, 1'b0, 32'd0, 2'd2, 1'b1, 32'd7, 2'd0);
      cdb_valid = 1'b0;
      check("disp_cdb_val1", alu_rval1, 32'd7);
      @(negedge clk);

      // Non-compare code is never taken
      sb.push_back(model(3'd6, 32'd1, 32'd1, 32'h400, 32'h80, 1'b1, 2'd3));
      disp(3'd6, 32'h400, 32'h80, 1'b1, 2'd3, 1'b1, 32'd1, 2'd0, 1'b1, 32'd1, 2'd0);
      @(negedge clk);

      for (int k = 0; k < 8; k++) begin
         f    = 3'($urandom_range(0, 7));
         a    = $urandom;
         b    = (k % 2 == 1) ? a : $urandom;
         pc   = $urandom & 32'hFFFFFFFC;
         imm  = $urandom;
         pred = 1'($urandom_range(0, 1));
         sb.push_back(model(f, a, b, pc, imm, pred, 2'(k)));
         disp(f, pc, imm, pred, 2'(k), 1'b1, a, 2'd0, 1'b1, b, 2'd0);
      end
      drain("drain_basic");

      // Fill all slots with waiting entries
      for (int k = 0; k < 4; k++) begin
         disp(3'd5, 32'h500 + 32'(k * 16), 32'd8, 1'b0, 2'(k), 1'b0, 32'd0, 2'(k), 1'b1, 32'd3, 2'd0);
      end
      check("full_ready", 32'(dispatch_ready), 32'd0);
      disp(3'd0, 32'h600, 32'd4, 1'b0, 2'd0, 1'b1, 32'd1, 2'd0, 1'b1, 32'd1, 2'd0);
      check("full_ready2", 32'(dispatch_ready), 32'd0);
      sb.push_back(model(3'd5, 32'd10, 32'd3, 32'h520, 32'd8, 1'b0, 2'd2));
      cdb(2'd2, 32'd10);
      check("full_sel",    alu_rval1,            32'd10);
      check("full_ready3", 32'(dispatch_ready),  32'd0);
      @(negedge clk);
      check("collapse_ready", 32'(dispatch_ready), 32'd1);
      sb.push_back(model(3'd5, 32'd1, 32'd3, 32'h530, 32'd8, 1'b0, 2'd3));
      cdb(2'd3, 32'd1);
      check("collapse_sel", alu_rval1, 32'd1);
      drain("drain_full");

      // Flush with three entries, one issuing, and a dispatch in the same cycle
      disp(3'd0, 32'h700, 32'd4, 1'b0, 2'd2, 1'b1, 32'd9, 2'd0, 1'b1, 32'd9, 2'd0);
      check("flush_pre_alu", alu_rval1, 32'd9);
      flush = 1'b1;
      disp(3'd0, 32'h800, 32'd4, 1'b0, 2'd1, 1'b1, 32'd2, 2'd0, 1'b1, 32'd2, 2'd0);
      flush = 1'b0;
      check("flush_res",   32'(res_valid),      32'd0);
      check("flush_ready", 32'(dispatch_ready), 32'd1);
      check("flush_alu",   alu_rval1,           32'd0);
      cdb(2'd0, 32'd1);
      cdb(2'd1, 32'd1);
      for (int k = 0; k < 3; k++) begin
         check("flush_dropped", 32'(res_valid), 32'd0);
         @(negedge clk);
      end

      // Two entries woken together issue back to back
      disp(3'd3, 32'h900, 32'h10, 1'b1, 2'd0, 1'b0, 32'd0, 2'd0, 1'b1, 32'd5, 2'd0);
      disp(3'd4, 32'hA00, 32'h20, 1'b0, 2'd1, 1'b0, 32'd0, 2'd0, 1'b1, 32'd5, 2'd0);
      sb.push_back(model(3'd3, 32'd6, 32'd5, 32'h900, 32'h10, 1'b1, 2'd0));
      sb.push_back(model(3'd4, 32'd6, 32'd5, 32'hA00, 32'h20, 1'b0, 2'd1));
      cdb(2'd0, 32'd6);
      check("pair_pre",   32'(res_valid), 32'd0);
      @(negedge clk);
      check("pair_r0",    32'(res_valid), 32'd1);
      @(negedge clk);
      check("pair_r1",    32'(res_valid), 32'd1);
      @(negedge clk);
      check("pair_after", 32'(res_valid), 32'd0);

      // Target wraps around 2^32
      sb.push_back(model(3'd0, 32'd3, 32'd3, 32'hFFFFFFFC, 32'd8, 1'b1, 2'd2));
      disp(3'd0, 32'hFFFFFFFC, 32'd8, 1'b1, 2'd2, 1'b1, 32'd3, 2'd0, 1'b1, 32'd3, 2'd0);
      @(negedge clk);
      drain("drain_wrap");

      // Asynchronous reset while a second entry is issuing
      sb.push_back(model(3'd1, 32'd1, 32'd2, 32'h1000, 32'h40, 1'b1, 2'd0));
      disp(3'd1, 32'h1000, 32'h40, 1'b1, 2'd0, 1'b1, 32'd1, 2'd0, 1'b1, 32'd2, 2'd0);
      disp(3'd0, 32'h2000, 32'h40, 1'b0, 2'd1, 1'b1, 32'd4, 2'd0, 1'b1, 32'd4, 2'd0);
      #1;
      rst = 1'b1;
      #1;
      check("rstm_res_valid", 32'(res_valid),      32'd0);
      check("rstm_target",    res_target,          32'd0);
      check("rstm_ready",     32'(dispatch_ready), 32'd1);
      check("rstm_alu",       alu_rval1,           32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      drain("drain_end");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/branch_rs.md
BRANCH_RS -- requirements
Module: branch_rs

Interface
REQ-001 SHALL have parameters: ROB_IX, default 2, ROB tag width; RS_DEPTH, default 4, number of entries.
REQ-002 SHALL have ports: clk_in  input  1  clock, rising edge.
REQ-003 SHALL have ports: rst_in  input  1  reset; asynchronous and active-high.
REQ-004 SHALL have dispatch ports: dispatch_valid_in  input  1; dispatch_ready_out  output  1; dispatch_brfunc_in  input  3 (Eq..Dbr encoding); dispatch_pc_in  input  32; dispatch_imm_in  input  32; dispatch_pred_taken_in  input  1; dispatch_robix_in  input  ROB_IX.
REQ-005 SHALL have source ports for n=1,2: srcN_rdy_in  input  1 (value present); srcN_val_in  input  32; srcN_tag_in  input  ROB_IX (producer tag when not ready).
REQ-006 SHALL have CDB ports: cdb_valid_in  input  1; cdb_tag_in  input  ROB_IX; cdb_val_in  input  32; and flush_in  input  1 (mispredict squash).
REQ-007 SHALL have ALU ports: alu_rval1_out  output  32; alu_rval2_out  output  32; alu_brfunc_out  output  3; alu_bool_in  input  1 (combinational compare result).
REQ-008 SHALL have result ports: res_valid_out  output  1; res_robix_out  output  ROB_IX; res_taken_out  output  1; res_target_out  output  32; res_mispredict_out  output  1.

Function
REQ-009 SHALL hold up to RS_DEPTH entries in a collapsing queue: index 0 is oldest, valid entries are contiguous from 0, and count is 0..RS_DEPTH.
REQ-010 SHALL drive dispatch_ready_out = (registered count < RS_DEPTH), independent of a same-cycle issue.
REQ-011 SHALL accept a dispatch at a rising edge when dispatch_valid_in && dispatch_ready_out && !flush_in, and SHALL ignore dispatch_valid_in otherwise.
REQ-012 SHALL write an accepted dispatch to the first free slot after any same-cycle collapse.
REQ-013 SHALL, for each valid entry operand not ready, capture cdb_val_in and set the operand ready when cdb_valid_in && cdb_tag_in equals its tag.
REQ-014 SHALL apply the same CDB match to operands of the dispatch being accepted in that cycle, so the CDB value is captured, not lost.
REQ-015 SHALL mark an entry ready when both operands are ready, using registered bits; dispatch or CDB capture in cycle N makes an entry eligible at cycle N+1 earliest.
REQ-016 SHALL select, combinationally each cycle, the lowest-index ready entry as the issue entry.
REQ-017 SHALL drive alu_* from the selected entry, and SHALL drive alu_* to 0 when no entry is selected.
REQ-018 SHALL, at the edge ending an issue cycle, remove the issued entry and shift all higher entries down by one.
REQ-019 SHALL register the result of each issue: res_valid_out=1 for exactly one cycle, at cycle N+1 for issue at cycle N.
REQ-020 SHALL set res_taken_out = alu_bool_in for brfunc codes 0..5, and 0 for any other code.
REQ-021 SHALL set res_target_out = pc+imm (mod 2^32) if taken, else pc+4 (mod 2^32).
REQ-022 SHALL set res_mispredict_out = res_taken_out XOR pred_taken, and res_robix_out = the entry's robix.
REQ-023 SHALL, while res_valid_out=0, hold res_robix/taken/target/mispredict at their last values.
REQ-024 SHALL, on flush_in=1 at an edge, clear all entries (count=0) and force res_valid_out=0 next cycle; flush takes priority over dispatch, issue and CDB capture.
REQ-025 SHALL leave a result already on res_* during the flush cycle visible for that cycle.
REQ-026 SHALL allow at most one dispatch and one issue per cycle; when both occur together, count is unchanged.

Reset
REQ-027 SHALL, while rst_in=1 (asynchronous), clear all entry valid bits, set count=0, set res_valid_out=0, and set res_robix_out, res_taken_out, res_target_out and res_mispredict_out to 0.
REQ-028 SHALL, during and after reset, drive dispatch_ready_out=1 and alu_*=0.
REQ-029 SHALL, on reset mid-operation, discard in-flight entries and pending results with no res_valid_out pulse.

Verification
REQ-030 SHALL cover: dispatch Lt, src1=-1, src2=1, pc=0x100, imm=0x20, pred=0 -> 2 cycles later res_valid, taken=1, target=0x120, mispredict=1.
REQ-031 SHALL cover: dispatch Bne with src2 waiting on tag 1; CDB tag1 val=5 while src1=5 -> issue the next cycle; result taken=0, target=pc+4, mispredict=0 when pred=0.
REQ-032 SHALL cover: fill 4 entries all waiting -> dispatch_ready_out=0 and a 5th dispatch is ignored; wake entry 2 -> it issues, entries 3..4 collapse, ready=1.
REQ-033 SHALL cover: two entries become ready in the same cycle -> index 0 issues first and index 1 issues the next cycle, giving back-to-back res_valid.
REQ-034 SHALL cover: flush_in with 3 entries and an issue in progress -> count=0, no res_valid_out the next cycle, and a same-cycle dispatch is dropped.
REQ-035 SHALL cover: pc=0xFFFFFFFC, imm=8, taken -> target=0x00000004; and rst_in asserted mid-issue -> res_valid_out=0 immediately.
